// File: rtl/mprj_cfg_pkg.sv
// Shared types and defaults for the user-project pad configuration sequencer.
// Optional feature macro: MPRJ_CFG_CLKDIV_EN (programmable serial clock divider).
package mprj_cfg_pkg;

    localparam int NUM_PADS_DEF = 38;
    localparam int CFG_BITS_DEF = 13;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_REQ,
        FETCH_CAP,
        SHIFT,
        LOAD,
        DONE
    } state_t;

    // Cycles from the edge that samples start to the done pulse.
    function automatic int seq_latency(int num_pads, int cfg_bits, int h);
        return num_pads * (2 + 2 * h * cfg_bits) + 2 * h;
    endfunction

endpackage

// File: rtl/mprj_io_cfg_sequencer_if.sv
// Store-read, pad-chain and control bundle of the pad configuration sequencer.
// Optional feature macro: MPRJ_CFG_CLKDIV_EN adds the clk_div input.
interface mprj_io_cfg_sequencer_if
    import mprj_cfg_pkg::*;
#(
    parameter int NUM_PADS = NUM_PADS_DEF,
    parameter int CFG_BITS = CFG_BITS_DEF
);
    localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

    logic                start;
    logic                cfg_rd;
    logic [AW-1:0]       cfg_addr;
    logic [CFG_BITS-1:0] cfg_rdata;
    logic                serial_clock;
    logic                serial_data;
    logic                serial_load;
    logic                busy;
    logic                done;
`ifdef MPRJ_CFG_CLKDIV_EN
    logic [3:0]          clk_div;

    modport master (
        input  start, cfg_rdata, clk_div,
        output cfg_rd, cfg_addr, serial_clock, serial_data,
        output serial_load, busy, done
    );
    modport slave (
        output start, cfg_rdata, clk_div,
        input  cfg_rd, cfg_addr, serial_clock, serial_data,
        input  serial_load, busy, done
    );
`else
    modport master (
        input  start, cfg_rdata,
        output cfg_rd, cfg_addr, serial_clock, serial_data,
        output serial_load, busy, done
    );
    modport slave (
        output start, cfg_rdata,
        input  cfg_rd, cfg_addr, serial_clock, serial_data,
        input  serial_load, busy, done
    );
`endif

endinterface

// File: rtl/mprj_cfg_serializer.sv
// Word serializer: shift register, bit counter and half-period timer.
// Optional feature macro: MPRJ_CFG_CLKDIV_EN (half period = clk_div+1).
module mprj_cfg_serializer
    import mprj_cfg_pkg::*;
#(
    parameter int CFG_BITS = CFG_BITS_DEF
) (
    input  logic                clock,
    input  logic                resetb,
`ifdef MPRJ_CFG_CLKDIV_EN
    input  logic                latch,
    input  logic [3:0]          clk_div,
`endif
    input  logic                load,
    input  logic [CFG_BITS-1:0] word,
    input  logic                shift_en,
    input  logic                wait_en,
    output logic                sclk,
    output logic                sdata,
    output logic                bit_done
);

    localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

    logic [CFG_BITS-1:0] sr;
    logic [BW-1:0]       bit_cnt;
    logic                half;
    logic                run;
    logic                tick;

    assign run = shift_en | wait_en;

`ifdef MPRJ_CFG_CLKDIV_EN
    logic [3:0] div_q;
    logic [3:0] hcnt;

    assign tick = (hcnt == 4'd0);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            div_q <= 4'd0;
            hcnt  <= 4'd0;
        end else begin
            if (latch)
                div_q <= clk_div;
            if (load)
                hcnt <= div_q;
            else if (run)
                hcnt <= tick ? div_q : hcnt - 4'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // half tracks the clock phase in both modes; sclk only toggles when shifting
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sr      <= '0;
            bit_cnt <= '0;
            half    <= 1'b0;
            sclk    <= 1'b0;
        end else if (load) begin
            sr      <= word;
            bit_cnt <= BW'(CFG_BITS - 1);
            half    <= 1'b0;
            sclk    <= 1'b0;
        end else if (run && tick) begin
            half <= ~half;
            sclk <= shift_en & ~half;
            if (half && shift_en) begin
                sr      <= sr << 1;
                bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

    assign sdata    = sr[CFG_BITS-1];
    assign bit_done = run & tick & half & (wait_en | (bit_cnt == '0));

endmodule

// File: rtl/mprj_io_cfg_sequencer.sv
// Loads every user-project pad's config word into the serial pad-control chain.
// Optional feature macro: MPRJ_CFG_CLKDIV_EN (programmable serial clock divider).
module mprj_io_cfg_sequencer
    import mprj_cfg_pkg::*;
#(
    parameter int NUM_PADS = NUM_PADS_DEF,
    parameter int CFG_BITS = CFG_BITS_DEF
) (
    input logic                    clock,
    input logic                    resetb,
    mprj_io_cfg_sequencer_if.master bus
);

    localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

    state_t        state;
    state_t        state_n;
    logic [AW-1:0] pad;
    logic [AW-1:0] pad_n;
    logic          bit_done;
    logic          sclk;
    logic          sdata;
    logic          rd_q;
    logic [AW-1:0] addr_q;
    logic          load_q;
    logic          busy_q;
    logic          done_q;

    mprj_cfg_serializer #(
        .CFG_BITS (CFG_BITS)
    ) u_ser (
        .clock    (clock),
        .resetb   (resetb),
`ifdef MPRJ_CFG_CLKDIV_EN
        .latch    ((state == IDLE) && bus.start),
        .clk_div  (bus.clk_div),
`endif
        .load     (state == FETCH_CAP),
        .word     (bus.cfg_rdata),
        .shift_en (state == SHIFT),
        .wait_en  (state == LOAD),
        .sclk     (sclk),
        .sdata    (sdata),
        .bit_done (bit_done)
    );

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
            pad   <= '0;
        end else begin
            state <= state_n;
            pad   <= pad_n;
        end
    end

    always_comb begin
        state_n = state;
        pad_n   = pad;
        unique case (state)
            IDLE: if (bus.start) begin
                state_n = FETCH_REQ;
                pad_n   = AW'(NUM_PADS - 1);
            end
            FETCH_REQ: state_n = FETCH_CAP;
            FETCH_CAP: state_n = SHIFT;
            SHIFT: if (bit_done) begin
                if (pad == '0) begin
                    state_n = LOAD;
                end else begin
                    state_n = FETCH_REQ;
                    pad_n   = pad - 1'b1;
                end
            end
            LOAD:    if (bit_done) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave straight from flops
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rd_q   <= 1'b0;
            addr_q <= '0;
            load_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rd_q   <= (state_n == FETCH_REQ);
            addr_q <= (state_n == FETCH_REQ) ? pad_n : '0;
            load_q <= (state_n == LOAD);
            busy_q <= (state_n != IDLE) && (state_n != DONE);
            done_q <= (state_n == DONE);
        end
    end

    assign bus.cfg_rd       = rd_q;
    assign bus.cfg_addr     = addr_q;
    assign bus.serial_clock = sclk;
    assign bus.serial_data  = sdata;
    assign bus.serial_load  = load_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_mprj_io_cfg_sequencer.sv
// Scoreboard bench for mprj_io_cfg_sequencer with a model pad chain.
// Optional feature macro: MPRJ_CFG_CLKDIV_EN (runs with clk_div = 3).
module tb_mprj_io_cfg_sequencer;
    import mprj_cfg_pkg::*;

    localparam int NP = NUM_PADS_DEF;
    localparam int B  = CFG_BITS_DEF;
`ifdef MPRJ_CFG_CLKDIV_EN
    localparam int H = 4;
`else
    localparam int H = 1;
`endif
    localparam int L = seq_latency(NP, B, H);

    logic clock = 1'b0;
    logic resetb = 1'b0;

    mprj_io_cfg_sequencer_if #(.NUM_PADS(NP), .CFG_BITS(B)) bus ();

    mprj_io_cfg_sequencer #(.NUM_PADS(NP), .CFG_BITS(B)) dut (
        .clock  (clock),
        .resetb (resetb),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    logic [B-1:0] store [NP];
    always @(posedge clock)
        bus.cfg_rdata <= bus.cfg_rd ? store[int'(bus.cfg_addr)] : '0;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    task automatic chk(string name, longint act, longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [B-1:0] pat(int k, int i);
        logic [B-1:0] w;
        case (k)
            0:       w = 13'h1000 | B'(i);
            1:       w = 13'h0A5A ^ B'(i * 'h123);
            default: w = 13'h1555 - B'(i);
        endcase
        return w;
    endfunction

    bit           exp_bits [$];
    logic [B-1:0] exp_words [$];
    int           exp_done [$];

    logic [NP*B-1:0] chain = '0;
    logic [B-1:0]    latched [NP];
    bit              prev_sclk, prev_load;
    int              rd_cnt, load_cnt, load_w, hi_w;

    // Monitor: chain model plus all scoreboard comparisons
    always @(negedge clock) begin
        if (!resetb) begin
            exp_bits.delete();
            exp_words.delete();
            exp_done.delete();
            {prev_sclk, prev_load} = 2'b00;
            rd_cnt = 0; load_cnt = 0; load_w = 0; hi_w = 0;
        end else begin
            if (bus.serial_clock && !prev_sclk) begin
                chain = {chain[NP*B-2:0], bus.serial_data};
                if (exp_bits.size() == 0)
                    chk("extra_serial_bit", 1, 0);
                else
                    chk("serial_data", bus.serial_data, exp_bits.pop_front());
            end
            if (bus.serial_clock) begin
                hi_w++;
            end else if (prev_sclk) begin
                chk("sclk_high_width", hi_w, H);
                hi_w = 0;
            end
            if (bus.serial_load && !prev_load) begin
                load_cnt++;
                for (int i = 0; i < NP; i++) latched[i] = chain[i*B +: B];
            end
            if (bus.serial_load) begin
                load_w++;
                chk("sclk_during_load", bus.serial_clock, 0);
            end
            if (bus.cfg_rd) rd_cnt++;
            if (bus.done) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("done_cycle", cyc, exp_done.pop_front());
                    chk("busy_in_done", bus.busy, 0);
                    chk("cfg_rd_count", rd_cnt, NP);
                    chk("load_pulses", load_cnt, 1);
                    chk("load_width", load_w, 2 * H);
                    for (int i = 0; i < NP; i++)
                        chk($sformatf("pad%0d_word", i), latched[i], exp_words.pop_front());
                end
                rd_cnt = 0; load_cnt = 0; load_w = 0;
            end
            prev_sclk = bus.serial_clock;
            prev_load = bus.serial_load;
        end
    end

    task automatic push_expect(int done_at);
        for (int p = NP - 1; p >= 0; p--)
            for (int b = B - 1; b >= 0; b--) begin
                logic [B-1:0] w;
                w = store[p];
                exp_bits.push_back(w[b]);
            end
        for (int i = 0; i < NP; i++) exp_words.push_back(store[i]);
        exp_done.push_back(done_at);
    endtask

    task automatic wait_done();
        for (int k = 0; k < L + 50; k++) begin
            @(negedge clock);
            if (bus.done) return;
        end
        chk("done_timeout", 1, 0);
    endtask

    task automatic chk_outs_zero(string name);
        chk(name, {bus.cfg_rd, bus.cfg_addr, bus.serial_clock, bus.serial_data,
                   bus.serial_load, bus.busy, bus.done}, 0);
    endtask

    task automatic fill(int k);
        for (int i = 0; i < NP; i++) store[i] = pat(k, i);
    endtask

    initial begin
        int t0;
        int bad;
        bus.start = 1'b0;
`ifdef MPRJ_CFG_CLKDIV_EN
        bus.clk_div = 4'd3;
`endif
        repeat (3) @(posedge clock);
        @(negedge clock) resetb = 1'b1;
        @(negedge clock);
        chk_outs_zero("reset_outputs");

        // Run 1: full load with restarts attempted while busy
        fill(0);
        @(posedge clock) #1 bus.start = 1'b1;
        push_expect(cyc + 1 + L);
        @(posedge clock) #1 bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        t0 = cyc;
        while (cyc < t0 + 99) @(posedge clock);
        #1 bus.start = 1'b1;
`ifdef MPRJ_CFG_CLKDIV_EN
        bus.clk_div = 4'd0;
`endif
        @(posedge clock) #1 bus.start = 1'b0;
        while (cyc < t0 + 499) @(posedge clock);
        #1 bus.start = 1'b1;
        @(posedge clock) #1 bus.start = 1'b0;
        wait_done();
        repeat (6) @(negedge clock);
        chk("idle_after_run1", bus.busy, 0);
`ifdef MPRJ_CFG_CLKDIV_EN
        bus.clk_div = 4'd3;
`endif

        // Run 2: reset during pad 20's shift
        fill(1);
        @(posedge clock) #1 bus.start = 1'b1;
        push_expect(cyc + 1 + L);
        @(posedge clock) #1 bus.start = 1'b0;
        bad = 1;
        for (int k = 0; k < L; k++) begin
            @(negedge clock);
            if (bus.cfg_rd && bus.cfg_addr == 20) begin
                bad = 0;
                break;
            end
        end
        chk("reached_pad20", bad, 0);
        repeat (5) @(posedge clock);
        #2 resetb = 1'b0;
        #1 chk_outs_zero("outputs_on_reset");
        repeat (2) @(negedge clock);
        bad = 0;
        for (int i = 0; i < NP; i++) if (latched[i] !== pat(0, i)) bad++;
        chk("latched_kept_after_reset", bad, 0);
        resetb = 1'b1;

        // Run 3: normal completion after the aborted sequence
        @(posedge clock) #1 bus.start = 1'b1;
        push_expect(cyc + 1 + L);
        @(posedge clock) #1 bus.start = 1'b0;
        wait_done();
        repeat (4) @(negedge clock);

        // Run 4: start held high gives back-to-back sequences
        fill(2);
        @(posedge clock) #1 bus.start = 1'b1;
        t0 = cyc + 1 + L;
        push_expect(t0);
        push_expect(t0 + 2 + L);
        wait_done();
        wait_done();
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        chk("idle_after_b2b", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mprj_io_cfg_sequencer.md
# mprj_io_cfg_sequencer

Serial configuration sequencer for the user-project I/O pads. It reads one configuration word per pad from the housekeeping configuration store and shifts all words, last pad first, into the daisy-chained per-pad control blocks that drive the `mprj_io_*` pad controls. It then pulses a load strobe so every pad latches its new configuration at once. It sits in the management domain, between the housekeeping register file and the pad control chain.

## Interface
Parameters:
- `NUM_PADS`, default 38: pads in the chain, equal to `MPRJ_IO_PADS`.
- `CFG_BITS`, default 13: configuration bits per pad.

Ports:
- `clock`, input, 1: management clock.
- `resetb`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a load sequence. Sampled only in IDLE.
- `cfg_rd`, output, 1: read strobe to the configuration store.
- `cfg_addr`, output, $clog2(NUM_PADS): pad index being read.
- `cfg_rdata`, input, CFG_BITS: store data, valid exactly one cycle after `cfg_rd`.
- `serial_clock`, output, 1: chain shift clock. The chain samples on its rising edge.
- `serial_data`, output, 1: chain serial data.
- `serial_load`, output, 1: chain latch strobe.
- `busy`, output, 1: sequence in progress.
- `done`, output, 1: one-cycle pulse when a sequence completes.
- `clk_div`, input, 4: half-period divisor. Present only with `MPRJ_CFG_CLKDIV_EN`.

## Operation
- States and transitions:
  - IDLE → FETCH_REQ, when `start` is high.
  - FETCH_REQ → FETCH_CAP, after 1 cycle.
  - FETCH_CAP → SHIFT, after 1 cycle.
  - SHIFT → FETCH_REQ, after the last bit, if pads remain.
  - SHIFT → LOAD, after the last bit of pad 0.
  - LOAD → DONE, after 2H cycles.
  - DONE → IDLE, after 1 cycle.
- Pad order is NUM_PADS-1 down to 0. After the full shift, pad 0's word is nearest the chain head.
- FETCH_REQ:
  - `cfg_rd`=1 and `cfg_addr`=current pad, for one cycle.
- FETCH_CAP:
  - `cfg_rdata` is captured into a CFG_BITS shift register.
  - The bit counter is set to CFG_BITS-1.
- SHIFT:
  - Bits go out MSB first.
  - Each bit uses 2H cycles: H cycles with `serial_clock`=0 and `serial_data`=current bit, then H cycles with `serial_clock`=1 and data held.
  - The shift register advances on the falling-edge transition.
- LOAD:
  - `serial_clock`=0 and `serial_load`=1 for 2H cycles, then `serial_load`=0.
- DONE:
  - `done`=1 for exactly one cycle. `busy` is already 0 in this cycle.
- `busy` is 1 in every state except IDLE and DONE.
- `start` while `busy` is high is ignored. A new sequence is not queued.
- `start` held high continuously re-triggers from IDLE, giving back-to-back sequences with one DONE cycle between them.

## Timing
- Reset values of all outputs are 0: `cfg_rd`, `cfg_addr`, `serial_clock`, `serial_data`, `serial_load`, `busy`, `done`. State resets to IDLE.
- H definition:
  - Without the macro, H = 1.
  - With the macro, H = `clk_div`+1, latched when `start` is accepted. Changes during `busy` have no effect.
- Latency, from the edge that samples `start` to the `done` pulse: NUM_PADS·(2 + 2H·CFG_BITS) + 2H cycles.
  - Defaults, H=1: 38·28 + 2 = 1066 cycles.
- `busy` rises on the cycle after `start` is sampled.
- Reset mid-sequence:
  - All outputs return to 0 asynchronously.
  - `serial_load` is never pulsed, so the chain's latched configuration is unchanged.
  - The partially shifted chain contents are don't-care.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `MPRJ_CFG_CLKDIV_EN` defined:
  - The `clk_div` port exists.
  - A 4-bit half-period counter slows `serial_clock` to `clock`/(2·(`clk_div`+1)).
- Not defined:
  - No `clk_div` port and no divider counter.
  - `serial_clock` runs at `clock`/2.
- Cycle ordering is otherwise identical in both builds.

## Structure
- Shared package `mprj_cfg_pkg` holds:
  - the state enum (IDLE, FETCH_REQ, FETCH_CAP, SHIFT, LOAD, DONE);
  - the defaults for `NUM_PADS` and `CFG_BITS`;
  - a function that computes sequence latency, used by the bench.
- One sub-module, `mprj_cfg_serializer`:
  - contains the shift register, the bit counter and the half-period timer;
  - its interface is load word / bit-done.
- The FSM, the pad counter and the read interface stay in the top module.

## Test plan
- Reset-value check: assert `resetb` low, release → all outputs are 0 and the FSM is in IDLE; a `start` pulse gives `busy`=1 on the next cycle.
- Full-chain load: defaults, store[i] = 13'h1000|i, model chain of 38×13-bit registers → after `done`, pad i holds 13'h1000|i; `done` arrives 1066 cycles after `start`; exactly one `serial_load` pulse, 2 cycles wide.
- Bit-order check: NUM_PADS=2, store = {13'h1AAA, 13'h0555} → the `serial_data` stream sampled at `serial_clock` rising edges is pad 1 MSB-first, then pad 0 MSB-first, 26 bits total.
- Busy-start check: pulse `start` again at cycle 100 and at cycle 500 of a sequence → ignored; exactly one `done` pulse; 38 `cfg_rd` strobes total.
- Reset mid-sequence: drop `resetb` during pad 20's SHIFT → outputs are 0 immediately; `serial_load` stays 0; the model chain's latched values are unchanged; a later `start` completes normally.
- Divider check, with `MPRJ_CFG_CLKDIV_EN`: `clk_div`=3 → `serial_clock` high and low phases are 4 cycles each; `done` arrives at 38·(2+8·13)+8 = 4036 cycles; changing `clk_div` mid-sequence does not change that timing.
